ttt_line_scanner: RTL and testbench
===================================

Name: ttt_line_scanner

Overview:
- Sequential, parametrised N x N winner detector for the tic-tac-toe datapath; replaces the fixed 3x3 combinational detector.
- On `start` it snapshots the board, then checks one line per cycle: N rows, N columns, 2 diagonals.
- Reports winner, player, winning line index, draw and error through a start/busy/done handshake.
- Sits between the board register file and the game-control FSM.

Parameters:
- N, 3, board dimension (N x N cells, N >= 3); a win requires all N cells of a line.
- NL, 2*N+2, localparam: number of lines scanned.
- LW, $clog2(2*N+2), localparam: width of line index (3 for N=3).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- start  in  1  request a scan; accepted only in IDLE.
- board  in  2*N*N  cell k=r*N+c at bits [2k+1:2k]; 00 empty, 01 X, 10 O, 11 illegal.
- busy  out  1  high while scanning.
- done  out  1  one-cycle pulse; results valid from this cycle.
- winner  out  1  exactly one player owns at least one complete line.
- who  out  2  01 X, 10 O, 00 none.
- win_line  out  LW  first (lowest-index) winning line:
  - 0..N-1 rows
  - N..2N-1 columns
  - 2N main diagonal (cells 0, N+1, ...)
  - 2N+1 anti-diagonal (cells N-1, 2N-2, ...)
- draw  out  1  every cell nonzero, no winner, no error.
- error  out  1  any cell is 11, or both players own a complete line.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE.
  - busy, done, winner, draw, error = 0; who=00; win_line=0.
  - Reset overrides start and takes effect mid-scan; the scan in progress is discarded.
- States:
  - IDLE: start=1 -> capture board into snapshot, line_idx=0, clear all result outputs and internal x_found/o_found/illegal flags, go to SCAN.
  - SCAN: evaluate snapshot line line_idx.
    - Line owned by p (01 or 10): all N cells equal p.
    - Any cell 11 in the evaluated line sets illegal.
    - On the first owned line of either player: record who_r=p, line_r=line_idx. Later owned lines never overwrite.
    - Set x_found or o_found accordingly.
    - If line_idx==NL-1 go to DONE; else line_idx+1.
  - DONE (one cycle): done=1, busy=0, results driven, then IDLE. Results hold until the next accepted start.
- Illegal cells off all lines cannot occur (every cell lies on a row), so row scanning covers the full board.
- Result resolution in DONE:
  - error = illegal | (x_found & o_found).
  - winner = (x_found ^ o_found) & ~illegal.
  - who = winner ? who_r : 00; win_line = winner ? line_r : 0.
  - draw = ~error & ~winner & (no 00 cell in snapshot).
  - winner, draw and error are mutually exclusive.
- Timing:
  - Start accepted at edge T; busy=1 in cycles T+1..T+NL.
  - done=1 in cycle T+NL+1; for N=3 that is 9 cycles after the accepting edge.
  - Minimum start-to-start spacing is NL+2 cycles.
- start while busy or done: ignored, no queuing.
- start held high continuously: a new scan begins in the IDLE cycle following DONE.
- Board changes during SCAN do not affect the result (snapshot).

Test Plan:
- N=3: cells 0,1,2 = 01, rest 00; pulse start -> done exactly 9 cycles later (busy high 8 cycles); winner=1, who=01, win_line=0, draw=0, error=0.
- N=3: cells 2,4,6 = 10, rest 00 -> winner=1, who=10, win_line=7. Also cells 0,4,8 = 01 -> win_line=6, who=01.
- N=3 full board, cells 0..8 = X,O,X, X,O,O, O,X,X -> winner=0, who=00, draw=1, error=0. Same board with cell 8 = 00 -> all flags 0.
- N=3: rows 0 all 01 and row 2 all 10 -> error=1, winner=0, who=00. Board with cell 5 = 11 -> error=1.
- Mid-scan: start, then drive rst_n=0 on cycle 4 -> outputs all zero next edge, no done pulse. Also start asserted during busy is ignored, and a board change during SCAN does not alter the result.
- N=4 rebuild: column 1 (cells 1,5,9,13) = 01 -> win_line=5, done 11 cycles after start. Also a board with cells 0,1,2 = 01 only -> no winner (a win needs all 4 cells).

Source files
------------

// File: rtl/ttt_line_scanner.sv
// Sequential N x N tic-tac-toe winner detector: snapshots the board on start,
// then evaluates one line per cycle (rows, columns, two diagonals) and reports the result.
module ttt_line_scanner #(
    parameter  int N  = 3,
    localparam int NL = 2*N + 2,
    localparam int LW = $clog2(2*N + 2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*N*N-1:0]     board,
    output logic                 busy,
    output logic                 done,
    output logic                 winner,
    output logic [1:0]           who,
    output logic [LW-1:0]        win_line,
    output logic                 draw,
    output logic                 error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [2*N*N-1:0]    snap_r;
    logic [LW-1:0]       line_idx_r;
    logic                x_found_r;
    logic                o_found_r;
    logic                illegal_r;
    logic [1:0]          who_r;
    logic [LW-1:0]       line_r;

    logic                all_x_s;
    logic                all_o_s;
    logic                ill_s;
    logic [1:0]          cell_s;
    logic                empty_s;
    logic                err_s;
    logic                win_s;
    logic                draw_s;

    // Cell index of the i-th cell on a line; the anti-diagonal runs N-1, 2N-2, ...
    function automatic int cell_idx(input logic [LW-1:0] line, input int i);
        int l;
        int k;
        l = int'(32'(line));
        if (l < N) begin
            k = l*N + i;
        end else if (l < 2*N) begin
            k = i*N + (l - N);
        end else if (l == 2*N) begin
            k = i*(N + 1);
        end else begin
            k = (i + 1)*(N - 1);
        end
        return k;
    endfunction

    // Mux one 2-bit cell out of a board with a constant-index loop.
    function automatic logic [1:0] get_cell(input logic [2*N*N-1:0] b, input int k);
        logic [1:0] c;
        c = 2'b00;
        for (int j = 0; j < N*N; j++) begin
            if (j == k) begin
                c = b[2*j +: 2];
            end else begin
                c = c;
            end
        end
        return c;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = SCAN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SCAN: begin
                if (line_idx_r == LW'(NL - 1)) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = SCAN;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Ownership and illegal-cell evaluation of the current line.
    always_comb begin
        all_x_s = 1'b1;
        all_o_s = 1'b1;
        ill_s   = 1'b0;
        cell_s  = 2'b00;
        for (int i = 0; i < N; i++) begin
            cell_s  = get_cell(snap_r, cell_idx(line_idx_r, i));
            all_x_s = all_x_s & (cell_s == 2'b01);
            all_o_s = all_o_s & (cell_s == 2'b10);
            ill_s   = ill_s | (cell_s == 2'b11);
        end
    end

    // Final resolution; the three verdicts are mutually exclusive by construction.
    always_comb begin
        empty_s = 1'b0;
        for (int j = 0; j < N*N; j++) begin
            if (snap_r[2*j +: 2] == 2'b00) begin
                empty_s = 1'b1;
            end else begin
                empty_s = empty_s;
            end
        end
        err_s  = illegal_r | (x_found_r & o_found_r);
        win_s  = (x_found_r ^ o_found_r) & ~illegal_r;
        draw_s = ~err_s & ~win_s & ~empty_s;
    end

    // Snapshot, scan accumulators and registered result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_r     <= {(2*N*N){1'b0}};
            line_idx_r <= {LW{1'b0}};
            x_found_r  <= 1'b0;
            o_found_r  <= 1'b0;
            illegal_r  <= 1'b0;
            who_r      <= 2'b00;
            line_r     <= {LW{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
            winner     <= 1'b0;
            who        <= 2'b00;
            win_line   <= {LW{1'b0}};
            draw       <= 1'b0;
            error      <= 1'b0;
        end else begin
            busy <= (state_r == SCAN);
            done <= (state_r == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        snap_r     <= board;
                        line_idx_r <= {LW{1'b0}};
                        x_found_r  <= 1'b0;
                        o_found_r  <= 1'b0;
                        illegal_r  <= 1'b0;
                        who_r      <= 2'b00;
                        line_r     <= {LW{1'b0}};
                        winner     <= 1'b0;
                        who        <= 2'b00;
                        win_line   <= {LW{1'b0}};
                        draw       <= 1'b0;
                        error      <= 1'b0;
                    end else begin
                        snap_r <= snap_r;
                    end
                end
                SCAN: begin
                    // Only the first owned line of either player is recorded.
                    if ((all_x_s | all_o_s) && !x_found_r && !o_found_r) begin
                        who_r  <= all_x_s ? 2'b01 : 2'b10;
                        line_r <= line_idx_r;
                    end else begin
                        who_r  <= who_r;
                    end
                    x_found_r  <= x_found_r | all_x_s;
                    o_found_r  <= o_found_r | all_o_s;
                    illegal_r  <= illegal_r | ill_s;
                    line_idx_r <= line_idx_r + LW'(1);
                end
                DONE: begin
                    error    <= err_s;
                    winner   <= win_s;
                    who      <= win_s ? who_r : 2'b00;
                    win_line <= win_s ? line_r : {LW{1'b0}};
                    draw     <= draw_s;
                end
                default: begin
                    line_idx_r <= {LW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ttt_line_scanner.sv
// Directed bench for ttt_line_scanner: an N=3 instance for the main function and
// handshake, plus an N=4 instance for the parametrised line geometry.
module tb_ttt_line_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start3, start4;
    logic [17:0] board3;
    logic [31:0] board4;

    logic        busy3, done3, winner3, draw3, error3;
    logic [1:0]  who3;
    logic [2:0]  win_line3;
    logic        busy4, done4, winner4, draw4, error4;
    logic [1:0]  who4;
    logic [3:0]  win_line4;

    int n_cmp = 0;
    int n_bad = 0;
    int lat, bcnt, first_done, second_done, done_seen;

    always #5 clk = ~clk;

    ttt_line_scanner #(.N(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .board(board3),
        .busy(busy3), .done(done3), .winner(winner3), .who(who3),
        .win_line(win_line3), .draw(draw3), .error(error3)
    );

    ttt_line_scanner #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .board(board4),
        .busy(busy4), .done(done4), .winner(winner4), .who(who4),
        .win_line(win_line4), .draw(draw4), .error(error4)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start on the selected instance and wait (bounded) for done.
    task automatic do_scan(input int sel, input logic [31:0] b, input bit disturb,
                           output int l, output int bc);
        l  = 0;
        bc = 0;
        if (sel == 3) begin board3 = b[17:0]; start3 = 1'b1; end
        else          begin board4 = b;       start4 = 1'b1; end
        @(posedge clk); #1;
        start3 = 1'b0;
        start4 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (disturb && k == 3) begin
                start3 = 1'b1;
                board3 = 18'b00_00_00_10_10_10_00_00_00;
            end
            if (disturb && k == 4) start3 = 1'b0;
            if (sel == 3 ? busy3 : busy4) bc++;
            if (sel == 3 ? done3 : done4) begin
                l = k;
                break;
            end
        end
    endtask

    task automatic check_res3(input string t, input int w, input int p, input int ln,
                              input int d, input int e);
        check_val({t, ".winner"},   32'(winner3),   w);
        check_val({t, ".who"},      32'(who3),      p);
        check_val({t, ".win_line"}, 32'(win_line3), ln);
        check_val({t, ".draw"},     32'(draw3),     d);
        check_val({t, ".error"},    32'(error3),    e);
    endtask

    initial begin
        rst_n  = 1'b0;
        start3 = 1'b0;
        start4 = 1'b0;
        board3 = 18'd0;
        board4 = 32'd0;
        start3 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start3 = 1'b0;
        check_val("reset3", 32'({busy3, done3, winner3, who3, win_line3, draw3, error3}), 0);
        check_val("reset4", 32'({busy4, done4, winner4, who4, win_line4, draw4, error4}), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Row 0 owned by X: latency and busy width.
        do_scan(3, 32'(18'b00_00_00_00_00_00_01_01_01), 1'b0, lat, bcnt);
        check_val("row0.latency", lat, 9);
        check_val("row0.busy_cycles", bcnt, 8);
        check_res3("row0", 1, 1, 0, 0, 0);
        @(posedge clk); #1;
        check_val("row0.hold", 32'({winner3, who3, win_line3}), 32'({1'b1, 2'b01, 3'd0}));
        check_val("row0.done_pulse", 32'(done3), 0);

        do_scan(3, 32'(18'b00_00_10_00_10_00_10_00_00), 1'b0, lat, bcnt);
        check_res3("anti_diag_o", 1, 2, 7, 0, 0);

        do_scan(3, 32'(18'b01_00_00_00_01_00_00_00_01), 1'b0, lat, bcnt);
        check_res3("main_diag_x", 1, 1, 6, 0, 0);

        do_scan(3, 32'(18'b01_01_10_10_10_01_01_10_01), 1'b0, lat, bcnt);
        check_res3("draw_full", 0, 0, 0, 1, 0);

        do_scan(3, 32'(18'b00_01_10_10_10_01_01_10_01), 1'b0, lat, bcnt);
        check_res3("not_full", 0, 0, 0, 0, 0);

        do_scan(3, 32'(18'b10_10_10_00_00_00_01_01_01), 1'b0, lat, bcnt);
        check_res3("both_win", 0, 0, 0, 0, 1);

        do_scan(3, 32'(18'b00_00_00_11_00_00_01_01_01), 1'b0, lat, bcnt);
        check_res3("illegal_cell", 0, 0, 0, 0, 1);

        // Mid-scan reset discards the scan and clears the previous error result.
        board3 = 18'b00_00_00_00_00_00_01_01_01;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_val("midrst.outputs",
                  32'({busy3, done3, winner3, who3, win_line3, draw3, error3}), 0);
        rst_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done3) done_seen++;
        end
        check_val("midrst.no_done", done_seen, 0);

        // Start during busy ignored, board change during scan has no effect.
        do_scan(3, 32'(18'b00_00_00_00_00_00_01_01_01), 1'b1, lat, bcnt);
        check_val("disturb.latency", lat, 9);
        check_res3("disturb", 1, 1, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("disturb.no_queue", 32'(busy3), 0);

        // Start held high: back-to-back scans spaced NL+2 cycles.
        board3 = 18'b00_00_00_00_00_00_01_01_01;
        start3 = 1'b1;
        @(posedge clk); #1;
        first_done  = 0;
        second_done = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done3 && first_done == 0) first_done = k;
            else if (done3) begin
                second_done = k;
                break;
            end
        end
        start3 = 1'b0;
        check_val("held.first_done", first_done, 9);
        check_val("held.second_done", second_done, 19);
        @(posedge clk); #1;

        // N=4: column 1 owned by X, and a three-in-a-row that is not a win.
        do_scan(4, 32'h0404_0404, 1'b0, lat, bcnt);
        check_val("n4.latency", lat, 11);
        check_val("n4.busy_cycles", bcnt, 10);
        check_val("n4.col1", 32'({winner4, who4, win_line4, draw4, error4}),
                  32'({1'b1, 2'b01, 4'd5, 1'b0, 1'b0}));
        do_scan(4, 32'h0000_0015, 1'b0, lat, bcnt);
        check_val("n4.three_only", 32'({winner4, who4, win_line4, draw4, error4}), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
